// File: rtl/cla_serial_adder_pkg.sv
// -----------------------------------------------------------------------------
// cla_serial_adder_pkg
// Shared definitions for the nibble-serial carry-lookahead adder.
//   SLICE_W     : width of the single lookahead slice reused every cycle
//   state_t     : controller state encoding (2'd3 is unused and recovers to IDLE)
//   signed_ovf  : two's-complement overflow from operand and result sign bits
// -----------------------------------------------------------------------------
package cla_serial_adder_pkg;

  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Overflow happens only when both operands share a sign and the result
  // sign differs from it.
  function automatic logic signed_ovf(input logic a_msb,
                                      input logic b_msb,
                                      input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/cla_serial_adder_cla4.sv
// -----------------------------------------------------------------------------
// cla4
// Purely combinational 4-bit carry-lookahead slice.
//   s  [3:0] : sum of a + b + ci
//   co       : carry out of bit 3
//   a  [3:0] : operand A nibble
//   b  [3:0] : operand B nibble
//   ci       : carry in to bit 0
// Every internal carry is a flat sum-of-products of generate/propagate terms,
// so no carry ripples through another bit's sum logic.
// -----------------------------------------------------------------------------
module cla4
  import cla_serial_adder_pkg::*;
(
  output logic [SLICE_W-1:0] s,
  output logic               co,
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               ci
);

  logic [SLICE_W-1:0] g;
  logic [SLICE_W-1:0] p;
  logic [SLICE_W:0]   c;

  genvar gi;
  generate
    for (gi = 0; gi < SLICE_W; gi++) begin : g_gp
      assign g[gi] = a[gi] & b[gi];
      assign p[gi] = a[gi] ^ b[gi];
    end
  endgenerate

  // Lookahead carries, each expressed directly in terms of g, p and ci.
  assign c[0] = ci;
  assign c[1] = g[0] | (p[0] & ci);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & ci);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & ci);

  generate
    for (gi = 0; gi < SLICE_W; gi++) begin : g_sum
      assign s[gi] = p[gi] ^ c[gi];
    end
  endgenerate

  assign co = c[SLICE_W];

endmodule

// File: rtl/cla_serial_adder.sv
// -----------------------------------------------------------------------------
// cla_serial_adder
// WIDTH-bit adder that pushes the operands through one cla4 slice, one nibble
// per cycle, least-significant nibble first, with a registered carry between
// nibbles.  Latency from accepted start to done is WIDTH/4 cycles.
//   clk    : clock, all state on the rising edge
//   reset  : synchronous active-high reset, clears everything incl. results
//   start  : request an addition, only looked at in IDLE
//   a, b   : operands, captured on the accepted start
//   ci     : carry in, captured on the accepted start
//   busy   : high while the nibble loop is running
//   done   : one-cycle pulse when s/co/ovf are updated
//   s      : sum, held until the next result
//   co     : carry out of bit WIDTH-1
//   ovf    : two's-complement overflow
// -----------------------------------------------------------------------------
module cla_serial_adder
  import cla_serial_adder_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ovf
);

  localparam int N     = WIDTH / SLICE_W;
  localparam int CNT_W = $clog2(N);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

  state_t                    state_reg;
  logic [CNT_W-1:0]          cnt_reg;
  logic [WIDTH-1:0]          a_reg;
  logic [WIDTH-1:0]          b_reg;
  logic                      carry_reg;
  // The operand shift registers lose their MSBs, so the signs are kept aside
  // for the overflow decision at the end.
  logic                      a_msb_reg;
  logic                      b_msb_reg;
  // Holds the nibbles produced so far; the current nibble is appended on top.
  logic [WIDTH-SLICE_W-1:0]  acc_reg;
  logic                      busy_reg;
  logic                      done_reg;
  logic [WIDTH-1:0]          s_reg;
  logic                      co_reg;
  logic                      ovf_reg;

  logic [SLICE_W-1:0]        slice_s;
  logic                      slice_co;
  logic [WIDTH-1:0]          acc_full;

  cla4 u_cla4 (
    .s  (slice_s),
    .co (slice_co),
    .a  (a_reg[SLICE_W-1:0]),
    .b  (b_reg[SLICE_W-1:0]),
    .ci (carry_reg)
  );

  // Accumulator with this cycle's nibble shifted in from the top.  On the
  // last nibble this is exactly the full sum.
  assign acc_full = {slice_s, acc_reg};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      carry_reg <= 1'b0;
      a_msb_reg <= 1'b0;
      b_msb_reg <= 1'b0;
      acc_reg   <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      s_reg     <= '0;
      co_reg    <= 1'b0;
      ovf_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          done_reg <= 1'b0;
          busy_reg <= 1'b0;
          if (start) begin
            a_reg     <= a;
            b_reg     <= b;
            carry_reg <= ci;
            a_msb_reg <= a[WIDTH-1];
            b_msb_reg <= b[WIDTH-1];
            cnt_reg   <= '0;
            busy_reg  <= 1'b1;
            state_reg <= RUN;
          end
        end

        RUN: begin
          acc_reg   <= acc_full[WIDTH-1:SLICE_W];
          a_reg     <= {{SLICE_W{1'b0}}, a_reg[WIDTH-1:SLICE_W]};
          b_reg     <= {{SLICE_W{1'b0}}, b_reg[WIDTH-1:SLICE_W]};
          carry_reg <= slice_co;
          cnt_reg   <= cnt_reg + 1'b1;
          if (cnt_reg == LAST_CNT) begin
            s_reg     <= acc_full;
            co_reg    <= slice_co;
            ovf_reg   <= signed_ovf(a_msb_reg, b_msb_reg, slice_s[SLICE_W-1]);
            done_reg  <= 1'b1;
            busy_reg  <= 1'b0;
            state_reg <= DONE;
          end
        end

        DONE: begin
          done_reg  <= 1'b0;
          state_reg <= IDLE;
        end

        default: begin
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign busy = busy_reg;
  assign done = done_reg;
  assign s    = s_reg;
  assign co   = co_reg;
  assign ovf  = ovf_reg;

endmodule

// File: tb/tb_cla_serial_adder.sv
module tb_cla_serial_adder;

  localparam int WIDTH = 32;
  localparam int N     = WIDTH / 4;

  logic             clk;
  logic             reset;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ci;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] s;
  logic             co;
  logic             ovf;

  int checks = 0;
  int errors = 0;

  cla_serial_adder #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .a     (a),
    .b     (b),
    .ci    (ci),
    .busy  (busy),
    .done  (done),
    .s     (s),
    .co    (co),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ci;
    logic [WIDTH-1:0] exp_s;
    logic             exp_co;
    logic             exp_ovf;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input logic ok, input string name,
                       input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one start pulse (called just after a rising edge) and follow the
  // operation to its done pulse, checking latency, busy, result and pulse width.
  task automatic do_op(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                       input logic vci, input logic [WIDTH-1:0] es,
                       input logic eco, input logic eovf, input int idx);
    int cycles;
    logic busy_ok;
    a = va; b = vb; ci = vci; start = 1'b1;
    tick();
    start = 1'b0;
    a = $urandom; b = $urandom; ci = 1'(($urandom));
    cycles  = 0;
    busy_ok = busy;
    while (!done && cycles < 20) begin
      tick();
      cycles++;
      if (!done && !busy) busy_ok = 1'b0;
    end
    check(cycles == N, "latency", 32'(cycles), 32'(N));
    check(busy_ok, "busy_during_run", {31'd0, busy_ok}, 32'd1);
    check(busy == 1'b0, "busy_at_done", {31'd0, busy}, 32'd0);
    check(s == es, "sum", s, es);
    check(co == eco, "carry_out", {31'd0, co}, {31'd0, eco});
    check(ovf == eovf, "overflow", {31'd0, ovf}, {31'd0, eovf});
    tick();
    check(done == 1'b0, "done_pulse_width", {31'd0, done}, 32'd0);
    $display("op %0d: a=0x%08h b=0x%08h ci=%0d -> s=0x%08h co=%0d ovf=%0d cycles=%0d",
             idx, va, vb, vci, s, co, ovf, cycles);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{32'h0000_0001, 32'h0000_0002, 1'b0, 32'h0000_0003, 1'b0, 1'b0};
    vecs[1] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
    vecs[2] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
    vecs[3] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
    vecs[4] = '{32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0};
    vecs[5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0};
    vecs[6] = '{32'hAAAA_AAAA, 32'h5555_5555, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0};
    vecs[7] = '{32'h0F0F_0F0F, 32'h0101_0101, 1'b0, 32'h1010_1010, 1'b0, 1'b0};

    // Reset with start held high and random operands: nothing is accepted.
    reset = 1'b1; start = 1'b1; a = $urandom; b = $urandom; ci = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      check(busy == 1'b0, "reset_busy", {31'd0, busy}, 32'd0);
      check(done == 1'b0, "reset_done", {31'd0, done}, 32'd0);
      check(s == '0, "reset_s", s, 32'd0);
      check({co, ovf} == 2'b00, "reset_co_ovf", {30'd0, co, ovf}, 32'd0);
      $display("reset cycle %0d: busy=%0d done=%0d s=0x%08h", i, busy, done, s);
    end
    start = 1'b0; reset = 1'b0;
    tick();
    check(busy == 1'b0, "post_reset_idle", {31'd0, busy}, 32'd0);

    // Table-driven directed vectors.
    for (int i = 0; i < 8; i++) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].ci, vecs[i].exp_s,
            vecs[i].exp_co, vecs[i].exp_ovf, i);
    end

    // Start held high through RUN and DONE, operand changed mid-run.
    begin
      int cycles;
      logic hold_ok;
      a = 32'd5; b = 32'd6; ci = 1'b0; start = 1'b1;
      tick();
      cycles = 0;
      while (!done && cycles < 20) begin
        tick();
        cycles++;
        if (cycles == 3) a = 32'hAAAA_AAAA;
      end
      check(cycles == N, "busy_start_latency", 32'(cycles), 32'(N));
      check(s == 32'h0000_000B, "busy_start_sum", s, 32'h0000_000B);
      tick();
      check(busy == 1'b0, "restart_gap_idle", {31'd0, busy}, 32'd0);
      check(s == 32'h0000_000B, "restart_gap_hold", s, 32'h0000_000B);
      tick();
      check(busy == 1'b1, "restart_accepted", {31'd0, busy}, 32'd1);
      start = 1'b0;
      hold_ok = 1'b1;
      cycles  = 0;
      while (!done && cycles < 20) begin
        if (s != 32'h0000_000B) hold_ok = 1'b0;
        tick();
        cycles++;
      end
      check(hold_ok, "sum_held_during_run", {31'd0, hold_ok}, 32'd1);
      check(cycles == N, "restart_latency", 32'(cycles), 32'(N));
      check(s == 32'hAAAA_AAB0, "restart_sum", s, 32'hAAAA_AAB0);
      check({co, ovf} == 2'b00, "restart_co_ovf", {30'd0, co, ovf}, 32'd0);
      $display("held-start: second result s=0x%08h co=%0d ovf=%0d", s, co, ovf);
      tick();
      tick();
    end

    // Reset in the middle of a computation.
    begin
      logic saw_done;
      a = 32'h1234_5678; b = 32'h1111_1111; ci = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      repeat (3) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check(busy == 1'b0, "midrun_reset_busy", {31'd0, busy}, 32'd0);
      check(s == '0, "midrun_reset_s", s, 32'd0);
      saw_done = done;
      for (int i = 0; i < 12; i++) begin
        tick();
        if (done) saw_done = 1'b1;
      end
      check(saw_done == 1'b0, "midrun_no_done", {31'd0, saw_done}, 32'd0);
      $display("mid-run reset: busy=%0d s=0x%08h done_seen=%0d", busy, s, saw_done);
      do_op(32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0, 99);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cla_serial_adder.md
Name: cla_serial_adder

Overview:
- Multi-cycle WIDTH-bit adder that reuses one 4-bit carry-lookahead slice (cla4) once per cycle, least-significant nibble first.
- A registered carry links successive nibbles.
- Sits directly downstream of the gate-level primitives and the cla4 slice: it consumes cla4's sum/carry outputs and presents a start/done handshake to the datapath.
- Trades latency (WIDTH/4 cycles) for area: only one cla4 instance regardless of WIDTH.

Parameters:
- WIDTH, 32, operand/sum width in bits; must be a multiple of 4 and >= 8.
- N (localparam), WIDTH/4, number of slice cycles per addition.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request a new addition; sampled only in IDLE.
- a  input  WIDTH  operand A; captured on the accepted start.
- b  input  WIDTH  operand B; captured on the accepted start.
- ci  input  1  carry-in; captured on the accepted start.
- busy  output  1  high while an addition is in progress (RUN state).
- done  output  1  one-cycle pulse; s/co/ovf valid from this cycle on.
- s  output  WIDTH  sum; held until the next result is written.
- co  output  1  carry-out of bit WIDTH-1.
- ovf  output  1  two's-complement overflow of the result.

Behaviour:
- Clocking and reset: single clock domain. reset is synchronous and active-high, with ports named clk and reset.
- Reset (any state, including mid-RUN):
  - state <= IDLE, busy = 0, done = 0, s = 0, co = 0, ovf = 0.
  - Nibble counter, carry register and operand registers <= 0.
  - Any partial sum is discarded.
- States:
  - IDLE: busy = 0, done = 0.
    - If start = 1 at edge k: latch a, b into shift registers; carry_r <= ci; cnt <= 0; state <= RUN.
  - RUN: busy = 1. Each edge:
    - cla4 adds a_r[3:0] + b_r[3:0] + carry_r.
    - Sum nibble shifts into the top of acc_r; acc_r, a_r and b_r shift right by 4.
    - carry_r <= cla4 co; cnt <= cnt + 1.
  - RUN exit: on the edge where cnt = N-1:
    - s <= final acc_r, including the current nibble; co <= cla4 co; ovf computed.
    - done <= 1, busy <= 0, state <= DONE.
  - DONE: done = 1 for exactly this cycle, then state <= IDLE. start is ignored in DONE.
- Latency: start accepted at edge k; results and done visible after edge k+N. For WIDTH = 32, done is high in the 8th cycle after acceptance.
- Minimum start-to-start spacing: N+2 cycles. With start held high continuously, the next operation is accepted at edge k+N+2.
- start while busy or in DONE: ignored. Operands are not re-latched and the current computation is unaffected.
- a, b and ci may change freely after acceptance; only the latched copies are used.
- s, co and ovf hold their last result through IDLE and the next RUN. They update only at RUN exit, never mid-computation.
- Arithmetic: {co, s} = a + b + ci, modulo 2^(WIDTH+1).
- ovf = (a_msb == b_msb) && (s[WIDTH-1] != a_msb). a_msb and b_msb are the MSBs of the latched operands, kept in a dedicated 1-bit register because the shift registers lose them.
- Carry across slices:
  - Propagates one nibble per cycle.
  - A full carry chain (e.g. all ones + ci) must resolve correctly through all N slices.
  - There is no early termination.
- cnt width: clog2(N); wrap-around is never reached because RUN exits at N-1.

Decomposition:
- Shared package:
  - SLICE_W = 4.
  - State encoding constants IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2. 2'd3 is illegal and recovers to IDLE on the next edge.
- One sub-module instance: cla4 (4-bit carry-lookahead slice built from the gate primitives; ports s[3:0], co, a[3:0], b[3:0], ci).
- FSM, shift registers and output registers live in the top module.

Test Plan:
- Reset: assert reset for 2 cycles with random inputs and start = 1 -> busy = 0, done = 0, s = 0, co = 0, ovf = 0; no operation accepted while reset = 1.
- Basic add: a = 0x0000_0001, b = 0x0000_0002, ci = 0, start pulse -> done high exactly 8 cycles after acceptance; s = 0x0000_0003, co = 0, ovf = 0; busy high for 8 cycles.
- Full carry ripple: a = 0xFFFF_FFFF, b = 0x0000_0000, ci = 1 -> s = 0x0000_0000, co = 1, ovf = 0.
- Signed overflow: a = 0x7FFF_FFFF, b = 0x0000_0001, ci = 0 -> s = 0x8000_0000, co = 0, ovf = 1. Also a = 0x8000_0000, b = 0x8000_0000 -> s = 0, co = 1, ovf = 1.
- Start during busy: accept a = 5, b = 6; at cycle 3 assert start with a = 0xAAAA_AAAA -> ignored; result s = 0x0000_000B. With start held high, the next op is accepted 2 cycles after done rises, and s holds 0xB until that op's done.
- Reset mid-RUN: accept a = 0x1234_5678, b = 0x1111_1111, assert reset at cycle 4 -> next cycle busy = 0 and s = 0, and no done pulse ever appears. A following op (a = 0x1234_5678, b = 0x1111_1111) yields s = 0x2345_6789, co = 0.
